// File: rtl/if_id_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer_if
// Description : Fetch/decode handshake bundle for the IF/ID pipeline buffer.
//               The master modport is the environment side that drives fetch
//               data and decode-ready. The slave modport is the buffer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface if_id_buffer_if;
    logic [31:0] IF_PC;
    logic [31:0] IF_INSTR;
    logic        IF_VALID;
    logic        IF_READY;
    logic        FLUSH;
    logic        ID_READY;
    logic        ID_VALID;
    logic [31:0] ID_PC;
    logic [31:0] ID_PC4;
    logic [31:0] ID_INSTR;

    modport master (
        output IF_PC, IF_INSTR, IF_VALID, FLUSH, ID_READY,
        input  IF_READY, ID_VALID, ID_PC, ID_PC4, ID_INSTR
    );

    modport slave (
        input  IF_PC, IF_INSTR, IF_VALID, FLUSH, ID_READY,
        output IF_READY, ID_VALID, ID_PC, ID_PC4, ID_INSTR
    );
endinterface
`default_nettype wire

// File: rtl/if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : if_id_buffer
// Description : Two-entry IF/ID pipeline FIFO between instruction fetch and
//               decode. All outputs decode from registered state only, so no
//               combinational path crosses the buffer in either direction.
//               Optional macro IFID_STALL_CNT_EN adds a STALL_CNT output that
//               counts cycles where decode holds off a valid head entry.
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_buffer (
    input  wire                 CLK,
    input  wire                 IFID_reset,
`ifdef IFID_STALL_CNT_EN
    output logic [31:0]         STALL_CNT,
`endif
    if_id_buffer_if.slave       bus
);

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [1:0]  DEPTH     = 2'd2;

    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] mem_pc    [2];
    logic [31:0] mem_instr [2];

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;

    assign full  = (count == DEPTH);
    assign empty = (count == 2'd0);

    // Flush suppresses both transfers; it has priority over push and pop.
    assign push = bus.IF_VALID && !full  && !bus.FLUSH;
    assign pop  = !empty && bus.ID_READY && !bus.FLUSH;

    // Occupancy, pointers and storage; reset beats flush beats push/pop.
    always_ff @(posedge CLK) begin
        if (IFID_reset) begin
            count        <= 2'd0;
            rd_ptr       <= 1'b0;
            wr_ptr       <= 1'b0;
            mem_pc[0]    <= 32'd0;
            mem_pc[1]    <= 32'd0;
            mem_instr[0] <= 32'd0;
            mem_instr[1] <= 32'd0;
        end else if (bus.FLUSH) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem_pc[wr_ptr]    <= bus.IF_PC;
                mem_instr[wr_ptr] <= bus.IF_INSTR;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves count unchanged.
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Head presentation: an empty buffer shows a NOP at PC 0.
    always_comb begin
        bus.IF_READY = !full;
        bus.ID_VALID = !empty;
        bus.ID_PC    = 32'd0;
        bus.ID_INSTR = NOP_INSTR;
        if (!empty) begin
            bus.ID_PC    = mem_pc[rd_ptr];
            bus.ID_INSTR = mem_instr[rd_ptr];
        end
        bus.ID_PC4 = bus.ID_PC + 32'd4;
    end

`ifdef IFID_STALL_CNT_EN
    // Count cycles where decode leaves a valid head waiting; flush has no effect.
    always_ff @(posedge CLK) begin
        if (IFID_reset) begin
            STALL_CNT <= 32'd0;
        end else if (!empty && !bus.ID_READY) begin
            STALL_CNT <= STALL_CNT + 32'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_buffer
// Description : Self-checking bench for if_id_buffer: directed scenarios plus
//               a randomized run checked against a queue-based model.
//               Define IFID_STALL_CNT_EN to also exercise STALL_CNT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_buffer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef IFID_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    if_id_buffer_if bus ();

    if_id_buffer dut (
        .CLK        (clk),
        .IFID_reset (rst),
`ifdef IFID_STALL_CNT_EN
        .STALL_CNT  (stall_cnt),
`endif
        .bus        (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, then advance one edge and settle before sampling.
    task automatic drive(input logic r, input logic v, input logic [31:0] pc,
                         input logic [31:0] instr, input logic rdy, input logic fl);
        rst          = r;
        bus.IF_VALID = v;
        bus.IF_PC    = pc;
        bus.IF_INSTR = instr;
        bus.ID_READY = rdy;
        bus.FLUSH    = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (bus.ID_VALID !== 1'b0 || bus.IF_READY !== 1'b1) begin
            failures++;
            $display("FAIL reset_flags: valid=%b ready=%b, expected 0/1", bus.ID_VALID, bus.IF_READY);
        end
        checks++;
        if (bus.ID_PC !== 32'd0 || bus.ID_PC4 !== 32'd4 || bus.ID_INSTR !== 32'h13) begin
            failures++;
            $display("FAIL reset_head: pc=%h pc4=%h instr=%h, expected 0/4/13",
                     bus.ID_PC, bus.ID_PC4, bus.ID_INSTR);
        end
        // Reset mid-operation, with push, pop and flush all asserted.
        drive(1'b0, 1'b1, 32'h40, 32'h1, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h44, 32'h2, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 32'h48, 32'h3, 1'b1, 1'b1);
        checks++;
        if (bus.ID_VALID !== 1'b0 || bus.IF_READY !== 1'b1 || bus.ID_INSTR !== 32'h13) begin
            failures++;
            $display("FAIL reset_midop: valid=%b ready=%b instr=%h, expected 0/1/13",
                     bus.ID_VALID, bus.IF_READY, bus.ID_INSTR);
        end
    endtask

    task automatic test_single_push();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h100, 32'h00A0_0093, 1'b1, 1'b0);
        checks++;
        if (bus.ID_VALID !== 1'b1 || bus.ID_PC !== 32'h100 || bus.ID_PC4 !== 32'h104
            || bus.ID_INSTR !== 32'h00A0_0093) begin
            failures++;
            $display("FAIL single_push: valid=%b pc=%h pc4=%h instr=%h, expected 1/100/104/00a00093",
                     bus.ID_VALID, bus.ID_PC, bus.ID_PC4, bus.ID_INSTR);
        end
    endtask

    task automatic test_full();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h0, 32'hA0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h4, 32'hA4, 1'b0, 1'b0);
        checks++;
        if (bus.IF_READY !== 1'b0 || bus.ID_PC !== 32'h0) begin
            failures++;
            $display("FAIL full_ready: ready=%b pc=%h, expected 0/0", bus.IF_READY, bus.ID_PC);
        end
        drive(1'b0, 1'b1, 32'h8, 32'hA8, 1'b0, 1'b0);
        checks++;
        if (bus.ID_PC !== 32'h0 || bus.ID_INSTR !== 32'hA0 || bus.IF_READY !== 1'b0) begin
            failures++;
            $display("FAIL full_hold: pc=%h instr=%h ready=%b, expected 0/a0/0",
                     bus.ID_PC, bus.ID_INSTR, bus.IF_READY);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (bus.ID_VALID !== 1'b1 || bus.ID_PC !== 32'h4 || bus.IF_READY !== 1'b1) begin
            failures++;
            $display("FAIL full_pop: valid=%b pc=%h ready=%b, expected 1/4/1",
                     bus.ID_VALID, bus.ID_PC, bus.IF_READY);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (bus.ID_VALID !== 1'b0) begin
            failures++;
            $display("FAIL full_nooverflow: valid=%b pc=%h, expected 0", bus.ID_VALID, bus.ID_PC);
        end
    endtask

    task automatic test_push_pop();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h10, 32'hB0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h14, 32'hB4, 1'b1, 1'b0);
        checks++;
        if (bus.ID_VALID !== 1'b1 || bus.ID_PC !== 32'h14 || bus.IF_READY !== 1'b1
            || bus.ID_INSTR !== 32'hB4) begin
            failures++;
            $display("FAIL push_pop: valid=%b pc=%h ready=%b instr=%h, expected 1/14/1/b4",
                     bus.ID_VALID, bus.ID_PC, bus.IF_READY, bus.ID_INSTR);
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (bus.ID_VALID !== 1'b0) begin
            failures++;
            $display("FAIL push_pop_count: valid=%b, expected 0", bus.ID_VALID);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h20, 32'hC0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h24, 32'hC4, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h28, 32'hC8, 1'b1, 1'b1);
        checks++;
        if (bus.ID_VALID !== 1'b0 || bus.IF_READY !== 1'b1 || bus.ID_INSTR !== 32'h13
            || bus.ID_PC !== 32'h0) begin
            failures++;
            $display("FAIL flush: valid=%b ready=%b instr=%h pc=%h, expected 0/1/13/0",
                     bus.ID_VALID, bus.IF_READY, bus.ID_INSTR, bus.ID_PC);
        end
        // After flush the buffer restarts cleanly from pointer 0.
        drive(1'b0, 1'b1, 32'h30, 32'hD0, 1'b0, 1'b0);
        checks++;
        if (bus.ID_VALID !== 1'b1 || bus.ID_PC !== 32'h30) begin
            failures++;
            $display("FAIL flush_restart: valid=%b pc=%h, expected 1/30", bus.ID_VALID, bus.ID_PC);
        end
    endtask

    task automatic test_pc4_wrap();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 32'hE0, 1'b0, 1'b0);
        checks++;
        if (bus.ID_PC !== 32'hFFFF_FFFC || bus.ID_PC4 !== 32'h0) begin
            failures++;
            $display("FAIL pc4_wrap: pc=%h pc4=%h, expected fffffffc/0", bus.ID_PC, bus.ID_PC4);
        end
    endtask

`ifdef IFID_STALL_CNT_EN
    task automatic test_stall_cnt();
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 32'h50, 32'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL stall_cnt: got %0d, expected 3", stall_cnt);
        end
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        checks++;
        if (stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL stall_cnt_reset: got %0d, expected 0", stall_cnt);
        end
    endtask
`endif

    // Randomized traffic against a queue model of the buffer.
    task automatic test_random();
        logic [63:0] q[$];
        logic [31:0] exp_pc, exp_instr;
        logic        r, v, rdy, fl;
        logic [31:0] pc, instr;
        int          errs;
        logic [31:0] exp_stall;
        errs      = 0;
        exp_stall = 32'd0;
        drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r     = ($urandom_range(0, 99) == 0);
            fl    = ($urandom_range(0, 15) == 0);
            v     = ($urandom_range(0, 2) != 0);
            rdy   = ($urandom_range(0, 1) == 1);
            pc    = {$urandom} & 32'hFFFF_FFFC;
            instr = $urandom;
            // Model update for this edge.
            if (r) begin
                q.delete();
                exp_stall = 32'd0;
            end else begin
                if (q.size() != 0 && !rdy) exp_stall = exp_stall + 32'd1;
                if (fl) begin
                    q.delete();
                end else begin
                    logic can_push;
                    can_push = v && (q.size() < 2);
                    if (q.size() != 0 && rdy) void'(q.pop_front());
                    if (can_push) q.push_back({pc, instr});
                end
            end
            drive(r, v, pc, instr, rdy, fl);
            if (q.size() == 0) begin
                exp_pc    = 32'd0;
                exp_instr = 32'h13;
            end else begin
                exp_pc    = q[0][63:32];
                exp_instr = q[0][31:0];
            end
            checks++;
            if (bus.ID_VALID !== (q.size() != 0) || bus.IF_READY !== (q.size() < 2)
                || bus.ID_PC !== exp_pc || bus.ID_INSTR !== exp_instr
                || bus.ID_PC4 !== exp_pc + 32'd4) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random cyc %0d: v=%b r=%b pc=%h i=%h pc4=%h, expected v=%b r=%b pc=%h i=%h",
                             cyc, bus.ID_VALID, bus.IF_READY, bus.ID_PC, bus.ID_INSTR, bus.ID_PC4,
                             q.size() != 0, q.size() < 2, exp_pc, exp_instr);
            end
`ifdef IFID_STALL_CNT_EN
            checks++;
            if (stall_cnt !== exp_stall) begin
                failures++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_stall cyc %0d: got %0d, expected %0d", cyc, stall_cnt, exp_stall);
            end
`endif
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.IF_VALID = 1'b0;
        bus.IF_PC    = 32'd0;
        bus.IF_INSTR = 32'd0;
        bus.ID_READY = 1'b0;
        bus.FLUSH    = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_push();
        test_full();
        test_push_pop();
        test_flush();
        test_pc4_wrap();
`ifdef IFID_STALL_CNT_EN
        test_stall_cnt();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
